// File: rtl/alu_result_stage.sv
// alu_result_stage: two-entry result/flags buffer between the ALU and writeback, owning the NZCV register
module alu_result_stage #(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_z,
    input  logic         in_carry,
    input  logic         in_msb_sum,
    input  logic         in_a_msb,
    input  logic         in_b_msb,
    input  logic [3:0]   in_s,
    input  logic         in_set_flags,
    input  logic [R-1:0] in_dest,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_z,
    output logic [R-1:0] out_dest,
    output logic [3:0]   out_nzcv,
    output logic [3:0]   flags
);
    logic [1:0][N-1:0] z_q, z_d;
    logic [1:0][R-1:0] dest_q, dest_d;
    logic [1:0]        n_q, n_d, zf_q, zf_d, c_q, c_d, v_q, v_d, ar_q, ar_d, sf_q, sf_d;
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [3:0]        flags_q, flags_d;
    logic              push, pop, arith, ovf;
    logic              unused_s;

    assign unused_s  = ^in_s[2:1];
    assign in_ready  = cnt_q != 2'd2;
    assign out_valid = cnt_q != 2'd0;
    assign out_z     = z_q[rd_q];
    assign out_dest  = dest_q[rd_q];
    assign flags     = flags_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign arith     = !in_s[3];
    // add overflows when operand signs agree, subtract when they differ; either way the sum sign flipped
    assign ovf       = ((in_a_msb ^ in_b_msb) == in_s[0]) && (in_msb_sum != in_a_msb);
    // logic ops take C/V from the flags register as it stands when they reach the head
    assign out_nzcv  = {n_q[rd_q], zf_q[rd_q],
                        ar_q[rd_q] ? c_q[rd_q] : flags_q[1],
                        ar_q[rd_q] ? v_q[rd_q] : flags_q[0]};

    // capture a new entry at wr_ptr, advance pointers/count, commit head flags on pop
    always_comb begin
        z_d    = z_q;
        dest_d = dest_q;
        n_d    = n_q;
        zf_d   = zf_q;
        c_d    = c_q;
        v_d    = v_q;
        ar_d   = ar_q;
        sf_d   = sf_q;
        if (push) begin
            z_d[wr_q]    = in_z;
            dest_d[wr_q] = in_dest;
            n_d[wr_q]    = in_z[N-1];
            zf_d[wr_q]   = in_z == '0;
            c_d[wr_q]    = arith && in_carry;
            v_d[wr_q]    = arith && ovf;
            ar_d[wr_q]   = arith;
            sf_d[wr_q]   = in_set_flags;
        end
        wr_d    = wr_q ^ push;
        rd_d    = rd_q ^ pop;
        cnt_d   = cnt_q + 2'(push) - 2'(pop);
        flags_d = (pop && sf_q[rd_q]) ? out_nzcv : flags_q;
    end

    // state registers, cleared asynchronously so a reset discards queued results uncommitted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q     <= '0;
            dest_q  <= '0;
            n_q     <= '0;
            zf_q    <= '0;
            c_q     <= '0;
            v_q     <= '0;
            ar_q    <= '0;
            sf_q    <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= 2'd0;
            flags_q <= 4'b0000;
        end else begin
            z_q     <= z_d;
            dest_q  <= dest_d;
            n_q     <= n_d;
            zf_q    <= zf_d;
            c_q     <= c_d;
            v_q     <= v_d;
            ar_q    <= ar_d;
            sf_q    <= sf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end
endmodule
